pipeline_control_unit: RTL and testbench

Central sequencer for the five-stage MIPS pipeline. It owns the run/step/halt state of the core and issues the global `o_halt`, the decode-stage `o_stall` bubble request, the PC and IF/ID write enables, and the IF/ID flush. It sits between the debug unit (run/step/halt commands), the instruction-decode stage (HALT detect, jump taken, source registers) and the EX stage (load destination), and replaces ad-hoc halt/stall wiring at top level.

---
 rtl/pipe_ctrl_pkg.sv | 20 ++
 rtl/hazard_detector.sv | 25 ++
 rtl/pipeline_control_unit.sv | 160 ++++++++++++++++
 tb/tb_pipeline_control_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline control unit
//
// Contents:
//   state_t               sequencer states (IDLE, RUN, STEP, DRAIN, DONE)
//   HALT_INSTR            encoding of the HALT instruction
//   DEFAULT_DRAIN_CYCLES  default number of EX/MEM/WB drain cycles
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [31:0] HALT_INSTR           = 32'hFFFF_FFFF;
    localparam int          DEFAULT_DRAIN_CYCLES = 4;

endpackage

// File: rtl/hazard_detector.sv
// rtl/hazard_detector.sv - combinational load-use hazard comparator
//
// Ports:
//   i_ex_mem_read  in   instruction in EX is a load
//   i_ex_rt        in   destination register of the EX load
//   i_id_rs        in   first source register of the instruction in ID
//   i_id_rt        in   second source register of the instruction in ID
//   o_hazard       out  ID consumes the EX load result next cycle
module hazard_detector (
    input  logic       i_ex_mem_read,
    input  logic [4:0] i_ex_rt,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    output logic       o_hazard
);

    logic w_rt_nonzero;
    logic w_src_match;

    // $zero is never a real dependency, so a load targeting r0 cannot stall.
    assign w_rt_nonzero = (i_ex_rt != 5'd0);
    assign w_src_match  = (i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt);
    assign o_hazard     = i_ex_mem_read && w_rt_nonzero && w_src_match;

endmodule

// File: rtl/pipeline_control_unit.sv
// rtl/pipeline_control_unit.sv - run/step/halt sequencer and stall control for the 5-stage pipeline
//
// Parameters:
//   DRAIN_CYCLES   cycles spent draining EX/MEM/WB after HALT reaches ID (1..8)
//   NB_CYCLE       width of the active-cycle counter
// Optional feature macro:
//   PIPE_CTRL_CYCLE_COUNT_EN  enables the active-cycle counter on o_cycle_count
// Ports:
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_run, i_step          debug free-run level / single-step pulse
//   i_halt_req             debug freeze request
//   i_halt_instr           ID holds the HALT encoding
//   i_jump                 ID resolved a taken branch/jump
//   i_id_rs, i_id_rt       ID source registers
//   i_ex_rt, i_ex_mem_read EX destination register / EX is a load
//   o_halt                 freeze all pipeline registers
//   o_stall                insert bubble in ID
//   o_pc_write             PC enable
//   o_ifid_write           IF/ID enable
//   o_ifid_flush           IF/ID clear (jump squash)
//   o_done                 program finished and drained
//   o_cycle_count          active-cycle count (0 when feature disabled)
import pipe_ctrl_pkg::*;

module pipeline_control_unit #(
    parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES,
    parameter int NB_CYCLE     = 32
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_run,
    input  logic                i_step,
    input  logic                i_halt_req,
    input  logic                i_halt_instr,
    input  logic                i_jump,
    input  logic [4:0]          i_id_rs,
    input  logic [4:0]          i_id_rt,
    input  logic [4:0]          i_ex_rt,
    input  logic                i_ex_mem_read,
    output logic                o_halt,
    output logic                o_stall,
    output logic                o_pc_write,
    output logic                o_ifid_write,
    output logic                o_ifid_flush,
    output logic                o_done,
    output logic [NB_CYCLE-1:0] o_cycle_count
);

    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [2:0] r_drain_cnt;
    logic       w_hazard;
    logic       w_halt;

    hazard_detector u_hazard_detector (
        .i_ex_mem_read (i_ex_mem_read),
        .i_ex_rt       (i_ex_rt),
        .i_id_rs       (i_id_rs),
        .i_id_rt       (i_id_rt),
        .o_hazard      (w_hazard)
    );

    // State register plus the drain down-counter that qualifies DRAIN exit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= 3'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state != ST_DRAIN && w_next_state == ST_DRAIN) begin
                r_drain_cnt <= DRAIN_LOAD;
            end else if (r_state == ST_DRAIN && r_drain_cnt != 3'd0) begin
                r_drain_cnt <= r_drain_cnt - 3'd1;
            end
        end
    end

    // Next-state logic. HALT in ID outranks a debug halt request so the
    // program's own end is never lost behind a freeze.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_run)       w_next_state = ST_RUN;
                else if (i_step) w_next_state = ST_STEP;
            end
            ST_RUN: begin
                if (i_halt_instr)    w_next_state = ST_DRAIN;
                else if (i_halt_req) w_next_state = ST_IDLE;
            end
            ST_STEP: begin
                w_next_state = i_halt_instr ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                if (r_drain_cnt == 3'd0) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                w_next_state = ST_DONE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Output logic. A HALT in ID is treated like a load-use stall so the
    // fetch side freezes and nothing past HALT enters the pipeline.
    always_comb begin
        w_halt       = 1'b1;
        o_stall      = 1'b0;
        o_pc_write   = 1'b0;
        o_ifid_write = 1'b0;
        o_ifid_flush = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            ST_RUN, ST_STEP: begin
                w_halt = 1'b0;
                if (w_hazard || i_halt_instr) begin
                    o_stall = 1'b1;
                end else begin
                    o_pc_write   = 1'b1;
                    o_ifid_write = 1'b1;
                    o_ifid_flush = i_jump;
                end
            end
            ST_DRAIN: begin
                w_halt  = 1'b0;
                o_stall = 1'b1;
            end
            ST_DONE: begin
                o_done = 1'b1;
            end
            default: begin
                w_halt = 1'b1;
            end
        endcase
    end

    assign o_halt = w_halt;

`ifdef PIPE_CTRL_CYCLE_COUNT_EN
    logic [NB_CYCLE-1:0] r_cycle_count;

    // Counts every cycle the pipeline advances; wraps naturally.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cycle_count <= '0;
        end else if (!w_halt) begin
            r_cycle_count <= r_cycle_count + 1'b1;
        end
    end

    assign o_cycle_count = r_cycle_count;
`else
    assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_control_unit.sv
// tb/tb_pipeline_control_unit.sv - self-checking bench for pipeline_control_unit
import pipe_ctrl_pkg::*;

module tb_pipeline_control_unit;

    localparam int DRAIN = 4;
    localparam int NB    = 32;

    logic          i_clk;
    logic          i_reset;
    logic          i_run;
    logic          i_step;
    logic          i_halt_req;
    logic          i_halt_instr;
    logic          i_jump;
    logic [4:0]    i_id_rs;
    logic [4:0]    i_id_rt;
    logic [4:0]    i_ex_rt;
    logic          i_ex_mem_read;
    logic          o_halt;
    logic          o_stall;
    logic          o_pc_write;
    logic          o_ifid_write;
    logic          o_ifid_flush;
    logic          o_done;
    logic [NB-1:0] o_cycle_count;

    logic [31:0]   id_instr;
    int            n_checks;
    int            n_errors;

    assign i_halt_instr = (id_instr == HALT_INSTR);

    pipeline_control_unit #(
        .DRAIN_CYCLES (DRAIN),
        .NB_CYCLE     (NB)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_run         (i_run),
        .i_step        (i_step),
        .i_halt_req    (i_halt_req),
        .i_halt_instr  (i_halt_instr),
        .i_jump        (i_jump),
        .i_id_rs       (i_id_rs),
        .i_id_rt       (i_id_rt),
        .i_ex_rt       (i_ex_rt),
        .i_ex_mem_read (i_ex_mem_read),
        .o_halt        (o_halt),
        .o_stall       (o_stall),
        .o_pc_write    (o_pc_write),
        .o_ifid_write  (o_ifid_write),
        .o_ifid_flush  (o_ifid_flush),
        .o_done        (o_done),
        .o_cycle_count (o_cycle_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the core is either frozen (waiting or finished),
    // advancing freely, advancing for a single cycle, or flushing its tail.
    localparam int M_FROZEN   = 0;
    localparam int M_FREE     = 1;
    localparam int M_ONE_SHOT = 2;
    localparam int M_FLUSHING = 3;
    localparam int M_FINISHED = 4;

    int          m_mode;
    int          m_flush_left;
    logic [NB-1:0] m_count;
    bit          m_valid;

    initial begin
        m_mode       = M_FROZEN;
        m_flush_left = 0;
        m_count      = '0;
        m_valid      = 1'b0;
    end

    always @(posedge i_clk) begin
        if (i_reset) begin
            m_valid      <= 1'b1;
            m_mode       <= M_FROZEN;
            m_flush_left <= 0;
            m_count      <= '0;
        end else begin
            if (m_mode == M_FREE || m_mode == M_ONE_SHOT || m_mode == M_FLUSHING)
                m_count <= m_count + 1'b1;
            if (m_mode == M_FROZEN) begin
                if (i_run)       m_mode <= M_FREE;
                else if (i_step) m_mode <= M_ONE_SHOT;
            end else if (m_mode == M_FREE || m_mode == M_ONE_SHOT) begin
                if (id_instr == HALT_INSTR) begin
                    m_mode       <= M_FLUSHING;
                    m_flush_left <= DRAIN;
                end else if (m_mode == M_ONE_SHOT || i_halt_req) begin
                    m_mode <= M_FROZEN;
                end
            end else if (m_mode == M_FLUSHING) begin
                if (m_flush_left == 1) m_mode <= M_FINISHED;
                m_flush_left <= m_flush_left - 1;
            end
        end
    end

    // Compare process: every falling edge once the model has seen a reset.
    always @(negedge i_clk) begin
        if (m_valid) begin
            bit advancing;
            bit load_use;
            bit hold_fetch;
            logic [NB-1:0] exp_count;
            advancing  = (m_mode == M_FREE || m_mode == M_ONE_SHOT);
            load_use   = i_ex_mem_read && (i_ex_rt != 0) &&
                         ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));
            hold_fetch = load_use || (id_instr == HALT_INSTR);
`ifdef PIPE_CTRL_CYCLE_COUNT_EN
            exp_count = m_count;
`else
            exp_count = '0;
`endif
            check("halt",  32'(o_halt),       32'(!(advancing || m_mode == M_FLUSHING)));
            check("stall", 32'(o_stall),      32'((advancing && hold_fetch) || m_mode == M_FLUSHING));
            check("pcw",   32'(o_pc_write),   32'(advancing && !hold_fetch));
            check("ifidw", 32'(o_ifid_write), 32'(advancing && !hold_fetch));
            check("flush", 32'(o_ifid_flush), 32'(advancing && !hold_fetch && i_jump));
            check("done",  32'(o_done),       32'(m_mode == M_FINISHED));
            check("count", 32'(o_cycle_count), 32'(exp_count));
        end
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic clear_id_ex();
        i_jump        = 1'b0;
        i_id_rs       = 5'd0;
        i_id_rt       = 5'd0;
        i_ex_rt       = 5'd0;
        i_ex_mem_read = 1'b0;
        id_instr      = 32'h0000_0020;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        i_reset    = 1'b1;
        i_run      = 1'b0;
        i_step     = 1'b0;
        i_halt_req = 1'b0;
        clear_id_ex();
        tick(2);
        i_reset = 1'b0;
        #1;
        check("rst_halt",  32'(o_halt), 32'd1);
        check("rst_done",  32'(o_done), 32'd0);
        check("rst_pcw",   32'(o_pc_write), 32'd0);
        check("rst_count", 32'(o_cycle_count), 32'd0);

        // single step: exactly one active cycle
        i_step = 1'b1;
        tick(1);
        i_step = 1'b0;
        check("step_halt", 32'(o_halt), 32'd0);
        check("step_pcw",  32'(o_pc_write), 32'd1);
        tick(1);
        check("step_back", 32'(o_halt), 32'd1);
        tick(2);
        check("step_stay", 32'(o_halt), 32'd1);

        // free run with a load-use hazard, then a load into r0
        i_run = 1'b1;
        tick(1);
        i_run = 1'b0;
        i_ex_mem_read = 1'b1; i_ex_rt = 5'd5; i_id_rs = 5'd5;
        #1;
        check("hz_stall", 32'(o_stall), 32'd1);
        check("hz_pcw",   32'(o_pc_write), 32'd0);
        tick(1);
        clear_id_ex();
        #1;
        check("hz_over", 32'(o_stall), 32'd0);
        i_ex_mem_read = 1'b1; i_ex_rt = 5'd0; i_id_rs = 5'd0;
        #1;
        check("r0_stall", 32'(o_stall), 32'd0);
        check("r0_pcw",   32'(o_pc_write), 32'd1);
        tick(1);

        // jump squash, then jump masked by a hazard on rt
        clear_id_ex();
        i_jump = 1'b1;
        #1;
        check("jmp_flush", 32'(o_ifid_flush), 32'd1);
        i_ex_mem_read = 1'b1; i_ex_rt = 5'd3; i_id_rt = 5'd3;
        #1;
        check("jmp_hz_flush", 32'(o_ifid_flush), 32'd0);
        check("jmp_hz_stall", 32'(o_stall), 32'd1);
        tick(1);
        clear_id_ex();
        tick(2);

        // HALT reaches ID: four drain cycles then done
        id_instr = HALT_INSTR;
        #1;
        check("hlt_id_stall", 32'(o_stall), 32'd1);
        tick(1);
        clear_id_ex();
        for (int d = 0; d < DRAIN; d++) begin
            #1;
            check("drain_stall", 32'(o_stall), 32'd1);
            check("drain_halt",  32'(o_halt), 32'd0);
            check("drain_done",  32'(o_done), 32'd0);
            tick(1);
        end
        check("done_done", 32'(o_done), 32'd1);
        check("done_halt", 32'(o_halt), 32'd1);
        i_run = 1'b1;
        tick(1);
        i_run = 1'b0;
        tick(1);
        check("done_ignore_run", 32'(o_done), 32'd1);
        check("done_ignore_halt", 32'(o_halt), 32'd1);

        // HALT and halt request together: drain wins; reset in drain cycle 2
        i_reset = 1'b1;
        tick(1);
        i_reset = 1'b0;
        i_run = 1'b1;
        tick(1);
        i_run = 1'b0;
        id_instr   = HALT_INSTR;
        i_halt_req = 1'b1;
        tick(1);
        clear_id_ex();
        i_halt_req = 1'b0;
        check("both_halt",  32'(o_halt), 32'd0);
        check("both_stall", 32'(o_stall), 32'd1);
        tick(1);
        i_reset = 1'b1;
        tick(1);
        i_reset = 1'b0;
        check("rst_drain_halt", 32'(o_halt), 32'd1);
        check("rst_drain_done", 32'(o_done), 32'd0);
        tick(5);
        check("rst_drain_stay", 32'(o_done), 32'd0);

        // ten active cycles, then a debug halt request
        i_run = 1'b1;
        tick(1);
        i_run = 1'b0;
        tick(9);
        i_halt_req = 1'b1;
        tick(1);
        i_halt_req = 1'b0;
        tick(3);
        check("cnt_halt", 32'(o_halt), 32'd1);
`ifdef PIPE_CTRL_CYCLE_COUNT_EN
        check("cnt_ten", 32'(o_cycle_count), 32'd10);
`else
        check("cnt_zero", 32'(o_cycle_count), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
